// File: rtl/ysyx_040066_axi_bridge_pkg.sv
// Shared types and constants for the icache/dcache to AXI4 bridge.
// Holds the read/write FSM state enums and fixed AXI field values.
package ysyx_040066_axi_pkg;

    typedef enum logic [1:0] {
        R_IDLE,
        R_AR,
        R_DATA
    } rd_state_e;

    typedef enum logic [1:0] {
        W_IDLE,
        W_ADDR,
        W_DATA,
        W_RESP
    } wr_state_e;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [7:0] BURST_LEN  = 8'd7;
    localparam logic [2:0] SIZE_DWORD = 3'd3;
    localparam int         ID_INS     = 0;
    localparam int         ID_DATA    = 1;

    // A line burst always moves full 64-bit beats; singles use the requested size.
    function automatic logic [2:0] xfer_size(input logic burst, input logic [2:0] len);
        return burst ? SIZE_DWORD : len;
    endfunction

endpackage

// File: rtl/ysyx_040066_axi_bridge_if.sv
// AXI4 channel bundle between the bridge (master) and the memory slave.
interface ysyx_040066_axi_bridge_if #(
    parameter int ID_W = 4
);
    logic            awvalid;
    logic            awready;
    logic [63:0]     awaddr;
    logic [ID_W-1:0] awid;
    logic [7:0]      awlen;
    logic [2:0]      awsize;
    logic [1:0]      awburst;

    logic            wvalid;
    logic            wready;
    logic [63:0]     wdata;
    logic [7:0]      wstrb;
    logic            wlast;

    logic            bvalid;
    logic            bready;
    logic [1:0]      bresp;
    logic [ID_W-1:0] bid;

    logic            arvalid;
    logic            arready;
    logic [63:0]     araddr;
    logic [ID_W-1:0] arid;
    logic [7:0]      arlen;
    logic [2:0]      arsize;
    logic [1:0]      arburst;

    logic            rvalid;
    logic            rready;
    logic [63:0]     rdata;
    logic [1:0]      rresp;
    logic            rlast;
    logic [ID_W-1:0] rid;

    modport master (
        output awvalid, awaddr, awid, awlen, awsize, awburst,
        input  awready,
        output wvalid, wdata, wstrb, wlast,
        input  wready,
        input  bvalid, bresp, bid,
        output bready,
        output arvalid, araddr, arid, arlen, arsize, arburst,
        input  arready,
        input  rvalid, rdata, rresp, rlast, rid,
        output rready
    );

    modport slave (
        input  awvalid, awaddr, awid, awlen, awsize, awburst,
        output awready,
        input  wvalid, wdata, wstrb, wlast,
        output wready,
        output bvalid, bresp, bid,
        input  bready,
        input  arvalid, araddr, arid, arlen, arsize, arburst,
        output arready,
        output rvalid, rdata, rresp, rlast, rid,
        input  rready
    );

endinterface

// File: rtl/ysyx_040066_axi_wr_ctrl.sv
// Write path: turns a level-held dcache write request into one AXI4 AW/W/B
// transaction (single beat or 8-beat line), all outputs registered.
module ysyx_040066_axi_wr_ctrl
    import ysyx_040066_axi_pkg::*;
#(
    parameter int ID_W = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wr_req,
    input  logic            wr_burst,
    input  logic [2:0]      wr_len,
    input  logic [7:0]      wr_mask,
    input  logic [63:0]     wr_addr,
    input  logic [511:0]    wr_data,
    output logic            wr_ready,
    output logic            wr_err,
    output logic            awvalid,
    output logic [63:0]     awaddr,
    output logic [ID_W-1:0] awid,
    output logic [7:0]      awlen,
    output logic [2:0]      awsize,
    output logic [1:0]      awburst,
    input  logic            awready,
    output logic            wvalid,
    output logic [63:0]     wdata,
    output logic [7:0]      wstrb,
    output logic            wlast,
    input  logic            wready,
    input  logic            bvalid,
    input  logic [1:0]      bresp,
    input  logic [ID_W-1:0] bid,
    output logic            bready
);

    wr_state_e    state_reg;
    logic         hold_reg;
    logic [511:0] line_reg;
    logic [2:0]   beat_reg;
    logic [2:0]   beat_inc;
    logic [63:0]  line_beat [8];
    logic         w_hs;
    logic         aw_ok;
    logic         w_done;

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_beat
            assign line_beat[gi] = line_reg[64*gi +: 64];
        end
    endgenerate

    assign beat_inc = beat_reg + 3'd1;
    assign w_hs     = wvalid && wready;
    // AW and W retire independently; leave the address phase once AW is gone.
    assign aw_ok    = !awvalid || awready;
    assign w_done   = !wvalid || (wready && wlast);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= W_IDLE;
            hold_reg  <= 1'b0;
            line_reg  <= '0;
            beat_reg  <= '0;
            wr_ready  <= 1'b0;
            wr_err    <= 1'b0;
            awvalid   <= 1'b0;
            awaddr    <= '0;
            awid      <= '0;
            awlen     <= '0;
            awsize    <= '0;
            awburst   <= '0;
            wvalid    <= 1'b0;
            wdata     <= '0;
            wstrb     <= '0;
            wlast     <= 1'b0;
            bready    <= 1'b0;
        end else begin
            wr_ready <= 1'b0;
            wr_err   <= 1'b0;
            case (state_reg)
                W_IDLE: begin
                    hold_reg <= 1'b0;
                    if (wr_req && !hold_reg) begin
                        awvalid   <= 1'b1;
                        awaddr    <= wr_addr;
                        awid      <= ID_W'(ID_DATA);
                        awlen     <= wr_burst ? BURST_LEN : 8'd0;
                        awsize    <= xfer_size(wr_burst, wr_len);
                        awburst   <= BURST_INCR;
                        wvalid    <= 1'b1;
                        wdata     <= wr_data[63:0];
                        wstrb     <= wr_burst ? 8'hFF : wr_mask;
                        wlast     <= !wr_burst;
                        line_reg  <= wr_data;
                        beat_reg  <= '0;
                        state_reg <= W_ADDR;
                    end
                end
                W_ADDR, W_DATA: begin
                    if (awvalid && awready) begin
                        awvalid <= 1'b0;
                    end
                    if (w_hs) begin
                        if (wlast) begin
                            wvalid <= 1'b0;
                            wlast  <= 1'b0;
                        end else begin
                            beat_reg <= beat_inc;
                            wdata    <= line_beat[beat_inc];
                            wlast    <= (beat_inc == 3'd7);
                        end
                    end
                    if (aw_ok) begin
                        if (w_done) begin
                            bready    <= 1'b1;
                            state_reg <= W_RESP;
                        end else begin
                            state_reg <= W_DATA;
                        end
                    end
                end
                W_RESP: begin
                    if (bvalid) begin
                        bready    <= 1'b0;
                        wr_ready  <= 1'b1;
                        wr_err    <= (bresp != RESP_OKAY) || (bid != ID_W'(ID_DATA));
                        beat_reg  <= '0;
                        hold_reg  <= 1'b1;
                        state_reg <= W_IDLE;
                    end
                end
                default: state_reg <= W_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/ysyx_040066_axi_bridge.sv
// Bridge from the icache / dcache request ports to one AXI4 master port.
// Reads are arbitrated here (dcache first); writes live in the wr_ctrl sub-module.
module ysyx_040066_axi_bridge
    import ysyx_040066_axi_pkg::*;
#(
    parameter int ID_W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ins_req,
    input  logic         ins_burst,
    input  logic [63:0]  ins_addr,
    output logic         ins_ready,
    output logic         ins_err,
    output logic         ins_last,
    output logic [63:0]  ins_data,
    input  logic         rd_req,
    input  logic         rd_burst,
    input  logic [2:0]   rd_len,
    input  logic [63:0]  rd_addr,
    output logic         rd_ready,
    output logic         rd_err,
    output logic         rd_last,
    output logic [63:0]  rd_data,
    input  logic         wr_req,
    input  logic         wr_burst,
    input  logic [2:0]   wr_len,
    input  logic [7:0]   wr_mask,
    input  logic [63:0]  wr_addr,
    input  logic [511:0] wr_data,
    output logic         wr_ready,
    output logic         wr_err,
    ysyx_040066_axi_bridge_if.master axi
);

    rd_state_e       rd_state_reg;
    logic            rd_hold_reg;
    logic            grant_data_reg;
    logic            err_acc_reg;
    logic            arvalid_reg;
    logic            rready_reg;
    logic [63:0]     araddr_reg;
    logic [63:0]     rdata_reg;
    logic [ID_W-1:0] arid_reg;
    logic [7:0]      arlen_reg;
    logic [2:0]      arsize_reg;
    logic [1:0]      arburst_reg;
    logic            beat_bad;
    logic            sel_burst;

    assign axi.arvalid = arvalid_reg;
    assign axi.araddr  = araddr_reg;
    assign axi.arid    = arid_reg;
    assign axi.arlen   = arlen_reg;
    assign axi.arsize  = arsize_reg;
    assign axi.arburst = arburst_reg;
    assign axi.rready  = rready_reg;
    assign ins_data    = rdata_reg;
    assign rd_data     = rdata_reg;

    assign sel_burst = rd_req ? rd_burst : ins_burst;
    // A wrong rid is treated like an error response.
    assign beat_bad  = (axi.rresp != RESP_OKAY) || (axi.rid != arid_reg);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_state_reg   <= R_IDLE;
            rd_hold_reg    <= 1'b0;
            grant_data_reg <= 1'b0;
            err_acc_reg    <= 1'b0;
            arvalid_reg    <= 1'b0;
            rready_reg     <= 1'b0;
            araddr_reg     <= '0;
            rdata_reg      <= '0;
            arid_reg       <= '0;
            arlen_reg      <= '0;
            arsize_reg     <= '0;
            arburst_reg    <= '0;
            ins_ready      <= 1'b0;
            ins_err        <= 1'b0;
            ins_last       <= 1'b0;
            rd_ready       <= 1'b0;
            rd_err         <= 1'b0;
            rd_last        <= 1'b0;
        end else begin
            ins_ready <= 1'b0;
            ins_err   <= 1'b0;
            ins_last  <= 1'b0;
            rd_ready  <= 1'b0;
            rd_err    <= 1'b0;
            rd_last   <= 1'b0;
            case (rd_state_reg)
                R_IDLE: begin
                    // The hold cycle lets a just-served requester drop its req first.
                    rd_hold_reg <= 1'b0;
                    if (!rd_hold_reg && (rd_req || ins_req)) begin
                        grant_data_reg <= rd_req;
                        arvalid_reg    <= 1'b1;
                        araddr_reg     <= rd_req ? rd_addr : ins_addr;
                        arid_reg       <= rd_req ? ID_W'(ID_DATA) : ID_W'(ID_INS);
                        arlen_reg      <= sel_burst ? BURST_LEN : 8'd0;
                        arsize_reg     <= rd_req ? xfer_size(rd_burst, rd_len)
                                                 : xfer_size(ins_burst, SIZE_DWORD);
                        arburst_reg    <= BURST_INCR;
                        err_acc_reg    <= 1'b0;
                        rd_state_reg   <= R_AR;
                    end
                end
                R_AR: begin
                    if (axi.arready) begin
                        arvalid_reg  <= 1'b0;
                        rready_reg   <= 1'b1;
                        rd_state_reg <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (axi.rvalid) begin
                        rdata_reg   <= axi.rdata;
                        err_acc_reg <= err_acc_reg | beat_bad;
                        if (grant_data_reg) begin
                            rd_ready <= 1'b1;
                            rd_last  <= axi.rlast;
                            rd_err   <= axi.rlast & (err_acc_reg | beat_bad);
                        end else begin
                            ins_ready <= 1'b1;
                            ins_last  <= axi.rlast;
                            ins_err   <= axi.rlast & (err_acc_reg | beat_bad);
                        end
                        if (axi.rlast) begin
                            rready_reg   <= 1'b0;
                            rd_hold_reg  <= 1'b1;
                            rd_state_reg <= R_IDLE;
                        end
                    end
                end
                default: rd_state_reg <= R_IDLE;
            endcase
        end
    end

    ysyx_040066_axi_wr_ctrl #(
        .ID_W(ID_W)
    ) u_wr_ctrl (
        .clk      (clk),
        .rst      (rst),
        .wr_req   (wr_req),
        .wr_burst (wr_burst),
        .wr_len   (wr_len),
        .wr_mask  (wr_mask),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_ready (wr_ready),
        .wr_err   (wr_err),
        .awvalid  (axi.awvalid),
        .awaddr   (axi.awaddr),
        .awid     (axi.awid),
        .awlen    (axi.awlen),
        .awsize   (axi.awsize),
        .awburst  (axi.awburst),
        .awready  (axi.awready),
        .wvalid   (axi.wvalid),
        .wdata    (axi.wdata),
        .wstrb    (axi.wstrb),
        .wlast    (axi.wlast),
        .wready   (axi.wready),
        .bvalid   (axi.bvalid),
        .bresp    (axi.bresp),
        .bid      (axi.bid),
        .bready   (axi.bready)
    );

endmodule

// File: tb/tb_ysyx_040066_axi_bridge.sv
// Self-checking bench: the bench plays the AXI slave and both cache requesters,
// predicting every response from the bridge's transfer rules.
module tb_ysyx_040066_axi_bridge;

    localparam int ID_W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         ins_req, ins_burst;
    logic [63:0]  ins_addr;
    logic         ins_ready, ins_err, ins_last;
    logic [63:0]  ins_data;
    logic         rd_req, rd_burst;
    logic [2:0]   rd_len;
    logic [63:0]  rd_addr;
    logic         rd_ready, rd_err, rd_last;
    logic [63:0]  rd_data;
    logic         wr_req, wr_burst;
    logic [2:0]   wr_len;
    logic [7:0]   wr_mask;
    logic [63:0]  wr_addr;
    logic [511:0] wr_data;
    logic         wr_ready, wr_err;

    int vectors     = 0;
    int miscompares = 0;

    logic [63:0]     rb_data [8];
    logic [1:0]      rb_resp [8];
    logic [ID_W-1:0] rb_id   [8];

    always #5 clk = ~clk;

    ysyx_040066_axi_bridge_if #(.ID_W(ID_W)) axi ();

    ysyx_040066_axi_bridge #(.ID_W(ID_W)) dut (
        .clk(clk), .rst(rst),
        .ins_req(ins_req), .ins_burst(ins_burst), .ins_addr(ins_addr),
        .ins_ready(ins_ready), .ins_err(ins_err), .ins_last(ins_last), .ins_data(ins_data),
        .rd_req(rd_req), .rd_burst(rd_burst), .rd_len(rd_len), .rd_addr(rd_addr),
        .rd_ready(rd_ready), .rd_err(rd_err), .rd_last(rd_last), .rd_data(rd_data),
        .wr_req(wr_req), .wr_burst(wr_burst), .wr_len(wr_len), .wr_mask(wr_mask),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready), .wr_err(wr_err),
        .axi(axi)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [511:0] rand_line();
        logic [511:0] l;
        for (int i = 0; i < 16; i++) l[32*i +: 32] = $urandom;
        return l;
    endfunction

    task automatic fill_read(input int err_beat, input logic [1:0] resp,
                             input logic [ID_W-1:0] id_good, input int badid_beat);
        for (int i = 0; i < 8; i++) begin
            rb_data[i] = {$urandom, $urandom};
            rb_resp[i] = (i == err_beat) ? resp : 2'b00;
            rb_id[i]   = (i == badid_beat) ? (id_good ^ ID_W'(2)) : id_good;
        end
    endtask

    // Slave side of one read; returns just after beat index stop_after-1 when cut short.
    task automatic serve_read(input bit is_data, input logic [63:0] addr, input bit burst,
                              input logic [2:0] len, input int stop_after);
        int n;
        int t;
        bit acc;
        bit bad;
        logic [ID_W-1:0] exp_id;
        logic got_ready, got_last, got_err, oth_ready, oth_last, oth_err;
        logic [63:0] got_data;
        n      = burst ? 8 : 1;
        exp_id = is_data ? ID_W'(1) : ID_W'(0);
        t = 0;
        while (axi.arvalid !== 1'b1 && t < 50) begin
            tick();
            t++;
        end
        check("ar_valid", axi.arvalid, 1);
        if (axi.arvalid !== 1'b1) return;
        check("ar_addr", axi.araddr, addr);
        check("ar_len", axi.arlen, burst ? 7 : 0);
        check("ar_size", axi.arsize, burst ? 3 : len);
        check("ar_burst", axi.arburst, 1);
        check("ar_id", axi.arid, exp_id);
        repeat ($urandom_range(0, 2)) begin
            tick();
            check("ar_valid_held", axi.arvalid, 1);
        end
        axi.arready = 1'b1;
        tick();
        axi.arready = 1'b0;
        check("ar_drop", axi.arvalid, 0);
        acc = 1'b0;
        for (int b = 0; b < n; b++) begin
            if (b == stop_after) return;
            repeat ($urandom_range(0, 2)) begin
                tick();
                check("r_gap_ready", is_data ? rd_ready : ins_ready, 0);
            end
            check("r_ready", axi.rready, 1);
            axi.rvalid = 1'b1;
            axi.rdata  = rb_data[b];
            axi.rresp  = rb_resp[b];
            axi.rid    = rb_id[b];
            axi.rlast  = (b == n - 1);
            tick();
            axi.rvalid = 1'b0;
            axi.rlast  = 1'b0;
            bad = (rb_resp[b] != 2'b00) || (rb_id[b] != exp_id);
            acc = acc | bad;
            if (is_data) begin
                got_ready = rd_ready;  got_last = rd_last;  got_err = rd_err;  got_data = rd_data;
                oth_ready = ins_ready; oth_last = ins_last; oth_err = ins_err;
            end else begin
                got_ready = ins_ready; got_last = ins_last; got_err = ins_err; got_data = ins_data;
                oth_ready = rd_ready;  oth_last = rd_last;  oth_err = rd_err;
            end
            check("r_port_ready", got_ready, 1);
            check("r_port_data", got_data, rb_data[b]);
            check("r_port_last", got_last, (b == n - 1));
            check("r_port_err", got_err, (b == n - 1) ? acc : 1'b0);
            check("r_other_ready", oth_ready, 0);
            check("r_other_last", oth_last, 0);
            check("r_other_err", oth_err, 0);
        end
    endtask

    // Slave side of one write with random backpressure and an optional W stall.
    task automatic serve_write(input logic [63:0] addr, input bit burst, input logic [2:0] len,
                               input logic [7:0] mask, input logic [511:0] line,
                               input int stall_beat, input int stall_cyc,
                               input logic [1:0] bresp_v, input logic [ID_W-1:0] bid_v);
        int n, wb, stall_left;
        bit aw_done, b_done, aw_hs, w_hs, b_hs, exp_err;
        n = burst ? 8 : 1;
        wb = 0;
        aw_done = 1'b0;
        b_done = 1'b0;
        stall_left = stall_cyc;
        exp_err = (bresp_v != 2'b00) || (bid_v != ID_W'(1));
        for (int cyc = 0; cyc < 300 && !b_done; cyc++) begin
            axi.awready = !aw_done && ($urandom_range(0, 1) == 1);
            if (wb == stall_beat && stall_left > 0) begin
                axi.wready = 1'b0;
                stall_left--;
            end else begin
                axi.wready = ($urandom_range(0, 3) != 0);
            end
            axi.bvalid = aw_done && (wb == n) && ($urandom_range(0, 1) == 1);
            axi.bresp  = bresp_v;
            axi.bid    = bid_v;
            aw_hs = (axi.awvalid === 1'b1) && axi.awready;
            w_hs  = (axi.wvalid === 1'b1) && axi.wready;
            b_hs  = axi.bvalid && (axi.bready === 1'b1);
            if (aw_hs) begin
                check("aw_addr", axi.awaddr, addr);
                check("aw_len", axi.awlen, burst ? 7 : 0);
                check("aw_size", axi.awsize, burst ? 3 : len);
                check("aw_burst", axi.awburst, 1);
                check("aw_id", axi.awid, 1);
            end
            if (w_hs) begin
                check("w_in_range", (wb < n), 1);
                check("w_data", axi.wdata, line[64*wb +: 64]);
                check("w_strb", axi.wstrb, burst ? 8'hFF : mask);
                check("w_last", axi.wlast, (wb == n - 1));
            end
            tick();
            if (aw_hs) aw_done = 1'b1;
            if (w_hs) wb++;
            if (b_hs) begin
                check("wr_ready_pulse", wr_ready, 1);
                check("wr_err", wr_err, exp_err);
                b_done = 1'b1;
            end else begin
                check("wr_ready_idle", wr_ready, 0);
            end
        end
        axi.awready = 1'b0;
        axi.wready  = 1'b0;
        axi.bvalid  = 1'b0;
        check("wr_done", b_done, 1);
        check("w_beats", wb, n);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [511:0] line;
        rst = 1'b1;
        ins_req = 0; ins_burst = 0; ins_addr = '0;
        rd_req = 0; rd_burst = 0; rd_len = '0; rd_addr = '0;
        wr_req = 0; wr_burst = 0; wr_len = '0; wr_mask = '0; wr_addr = '0; wr_data = '0;
        axi.awready = 0; axi.wready = 0; axi.bvalid = 0; axi.bresp = '0; axi.bid = '0;
        axi.arready = 0; axi.rvalid = 0; axi.rdata = '0; axi.rresp = '0; axi.rlast = 0; axi.rid = '0;
        repeat (3) tick();
        check("rst_arvalid", axi.arvalid, 0);
        check("rst_awvalid", axi.awvalid, 0);
        check("rst_wvalid", axi.wvalid, 0);
        check("rst_rready", axi.rready, 0);
        check("rst_bready", axi.bready, 0);
        check("rst_ready", {ins_ready, rd_ready, wr_ready}, 0);
        check("rst_araddr", axi.araddr, 0);
        check("rst_awaddr", axi.awaddr, 0);
        rst = 1'b0;
        tick();

        // Instruction line fill with one-cycle AR latency.
        fill_read(-1, 2'b00, ID_W'(0), -1);
        ins_addr = 64'h8000_0040; ins_burst = 1'b1; ins_req = 1'b1;
        tick();
        check("ar_latency", axi.arvalid, 1);
        serve_read(1'b0, 64'h8000_0040, 1'b1, 3'd3, 8);
        tick();
        check("ins_hold_idle", axi.arvalid, 0);
        ins_req = 1'b0;
        tick();

        // Simultaneous requests: data wins, instruction follows after the hold cycle.
        fill_read(-1, 2'b00, ID_W'(1), -1);
        rd_addr = 64'h8000_3000; rd_burst = 1'b1; rd_len = 3'd3; rd_req = 1'b1;
        ins_addr = 64'h8000_1000; ins_burst = 1'b1; ins_req = 1'b1;
        serve_read(1'b1, 64'h8000_3000, 1'b1, 3'd3, 8);
        tick();
        check("rd_stale_not_regranted", axi.arvalid, 0);
        rd_req = 1'b0;
        fill_read(-1, 2'b00, ID_W'(0), -1);
        serve_read(1'b0, 64'h8000_1000, 1'b1, 3'd3, 8);
        ins_req = 1'b0;
        tick();

        // Single masked write.
        line = rand_line();
        wr_addr = 64'hA000_03F8; wr_burst = 1'b0; wr_len = 3'd2; wr_mask = 8'h0F; wr_data = line;
        wr_req = 1'b1;
        serve_write(64'hA000_03F8, 1'b0, 3'd2, 8'h0F, line, -1, 0, 2'b00, ID_W'(1));
        tick();
        check("wr_hold_idle", axi.awvalid, 0);
        wr_req = 1'b0;
        tick();

        // Burst write stalled on beat 4 with SLVERR.
        line = rand_line();
        wr_addr = 64'hA000_1000; wr_burst = 1'b1; wr_len = 3'd3; wr_data = line;
        wr_req = 1'b1;
        serve_write(64'hA000_1000, 1'b1, 3'd3, 8'hFF, line, 4, 3, 2'b10, ID_W'(1));
        wr_req = 1'b0;
        tick();

        // Randomized reads and writes with occasional error responses or stray IDs.
        for (int k = 0; k < 6; k++) begin
            bit d;
            bit bu;
            logic [2:0] ln;
            logic [63:0] a;
            logic [7:0] m;
            logic [1:0] br;
            logic [ID_W-1:0] bi;
            d  = 1'($urandom_range(0, 1));
            bu = d ? 1'($urandom_range(0, 1)) : 1'b1;
            ln = 3'($urandom_range(0, 3));
            a  = {32'h8000_0000, $urandom} & ~64'h7;
            fill_read($urandom_range(0, 15), 2'($urandom_range(1, 3)), d ? ID_W'(1) : ID_W'(0),
                      ($urandom_range(0, 3) == 0) ? $urandom_range(0, 7) : -1);
            if (d) begin
                rd_req = 1'b1; rd_burst = bu; rd_len = ln; rd_addr = a;
            end else begin
                ins_req = 1'b1; ins_burst = 1'b1; ins_addr = a;
            end
            serve_read(d, a, bu, ln, 8);
            tick();
            check("rand_rd_hold", axi.arvalid, 0);
            ins_req = 1'b0; rd_req = 1'b0;
            tick();

            bu   = 1'($urandom_range(0, 1));
            m    = 8'($urandom);
            line = rand_line();
            br   = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            bi   = ($urandom_range(0, 4) == 0) ? ID_W'(3) : ID_W'(1);
            wr_addr = a ^ 64'h100; wr_burst = bu; wr_len = ln; wr_mask = m; wr_data = line;
            wr_req = 1'b1;
            serve_write(a ^ 64'h100, bu, ln, m, line, -1, 0, br, bi);
            tick();
            check("rand_wr_hold", axi.awvalid, 0);
            wr_req = 1'b0;
            tick();
        end

        // Reset while beat 3 of an instruction fill is on the bus.
        fill_read(-1, 2'b00, ID_W'(0), -1);
        ins_addr = 64'h8000_2000; ins_burst = 1'b1; ins_req = 1'b1;
        serve_read(1'b0, 64'h8000_2000, 1'b1, 3'd3, 3);
        axi.rvalid = 1'b1; axi.rdata = rb_data[3]; axi.rid = '0; axi.rresp = '0; axi.rlast = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_ins_ready", ins_ready, 0);
        check("mid_rst_ins_last", ins_last, 0);
        check("mid_rst_ins_err", ins_err, 0);
        check("mid_rst_ins_data", ins_data, 0);
        check("mid_rst_rready", axi.rready, 0);
        check("mid_rst_arvalid", axi.arvalid, 0);
        check("mid_rst_araddr", axi.araddr, 0);
        axi.rvalid = 1'b0;
        ins_req = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        fill_read(-1, 2'b00, ID_W'(0), -1);
        ins_addr = 64'h8000_2000; ins_req = 1'b1;
        serve_read(1'b0, 64'h8000_2000, 1'b1, 3'd3, 8);
        ins_req = 1'b0;
        tick();
        tick();

        // Concurrent burst read and burst write.
        fill_read(-1, 2'b00, ID_W'(0), -1);
        line = rand_line();
        ins_addr = 64'h8000_4000; ins_burst = 1'b1; ins_req = 1'b1;
        wr_addr = 64'hA000_4000; wr_burst = 1'b1; wr_len = 3'd3; wr_data = line; wr_req = 1'b1;
        tick();
        check("ar_aw_same_cycle", {axi.arvalid, axi.awvalid}, 2'b11);
        fork
            begin
                serve_read(1'b0, 64'h8000_4000, 1'b1, 3'd3, 8);
                ins_req = 1'b0;
            end
            begin
                serve_write(64'hA000_4000, 1'b1, 3'd3, 8'hFF, line, -1, 0, 2'b00, ID_W'(1));
                wr_req = 1'b0;
            end
        join
        tick();
        tick();
        check("end_idle", {axi.arvalid, axi.awvalid, axi.wvalid}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
